// File: rtl/data_mem_dma_pkg.sv
// Shared types and width defaults for the data-memory block-copy DMA.
// Optional fill mode is enabled with DATA_MEM_DMA_FILL_EN.
package data_mem_dma_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int LEN_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } dma_state_e;
endpackage

// File: rtl/data_mem_dma_if.sv
// Control and memory-port bundle between the DMA (master) and core/arbiter/memory (slave).
// Fill-mode operands exist only when DATA_MEM_DMA_FILL_EN is defined.
interface data_mem_dma_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  words_done;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_A;
    logic [DATA_W-1:0] mem_WD;
    logic              mem_WE;
    logic              mem_RE;
    logic [DATA_W-1:0] mem_RD;
`ifdef DATA_MEM_DMA_FILL_EN
    logic              fill;
    logic [DATA_W-1:0] fill_val;

    modport master (
        input  start, src_addr, dst_addr, len, abort, mem_gnt, mem_RD, fill, fill_val,
        output busy, done, words_done, mem_req, mem_A, mem_WD, mem_WE, mem_RE
    );
    modport slave (
        output start, src_addr, dst_addr, len, abort, mem_gnt, mem_RD, fill, fill_val,
        input  busy, done, words_done, mem_req, mem_A, mem_WD, mem_WE, mem_RE
    );
`else
    modport master (
        input  start, src_addr, dst_addr, len, abort, mem_gnt, mem_RD,
        output busy, done, words_done, mem_req, mem_A, mem_WD, mem_WE, mem_RE
    );
    modport slave (
        output start, src_addr, dst_addr, len, abort, mem_gnt, mem_RD,
        input  busy, done, words_done, mem_req, mem_A, mem_WD, mem_WE, mem_RE
    );
`endif
endinterface

// File: rtl/data_mem_dma_addr_cnt.sv
// Loadable wrapping address incrementer; load wins over enable.
// Latency: 1 cycle from load/en to cnt_o; no backpressure.
module dma_addr_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/data_mem_dma.sv
// Block copy inside data memory via a req/gnt-arbitrated port (fill mode: DATA_MEM_DMA_FILL_EN).
// Latency: 2 cycles/word (fill: 1), done pulses 2N+2 cycles after start with gnt held high.
// Backpressure: mem_gnt low stalls in RD/WR with RE/WE deasserted; abort exits at the next edge.
module data_mem_dma
    import data_mem_dma_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_dma_if.master  bus
);
    dma_state_e        state_q;
    logic              busy_q, done_q;
    logic [LEN_W-1:0]  rem_q, words_q;
    logic [DATA_W-1:0] buf_q;
    logic [ADDR_W-1:0] src_w, dst_w;
    logic [DATA_W-1:0] wr_dat;
    logic              launch, rd_go, wr_go, fill_start, is_fill;

`ifdef DATA_MEM_DMA_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_val_q;
    assign fill_start = bus.fill;
    assign is_fill    = fill_q;
    assign wr_dat     = fill_q ? fill_val_q : buf_q;
`else
    assign fill_start = 1'b0;
    assign is_fill    = 1'b0;
    assign wr_dat     = buf_q;
`endif

    assign launch = (state_q == IDLE) && bus.start && !bus.abort;
    assign rd_go  = (state_q == RD) && bus.mem_gnt && !bus.abort;
    assign wr_go  = (state_q == WR) && bus.mem_gnt && !bus.abort;

    dma_addr_cnt #(.W(ADDR_W)) u_src_cnt (
        .clk(clk), .rst(rst), .load_i(launch), .load_val_i(bus.src_addr), .en_i(rd_go), .cnt_o(src_w)
    );
    dma_addr_cnt #(.W(ADDR_W)) u_dst_cnt (
        .clk(clk), .rst(rst), .load_i(launch), .load_val_i(bus.dst_addr), .en_i(wr_go), .cnt_o(dst_w)
    );

    // Memory strobes follow grant combinationally; an abort suppresses the write in its own cycle.
    always_comb begin
        bus.mem_req = (state_q == RD) || (state_q == WR);
        bus.mem_A   = '0;
        bus.mem_WD  = '0;
        bus.mem_WE  = 1'b0;
        bus.mem_RE  = 1'b0;
        if (bus.mem_gnt) begin
            if (state_q == RD) begin
                bus.mem_A  = src_w;
                bus.mem_RE = 1'b1;
            end else if (state_q == WR) begin
                bus.mem_A  = dst_w;
                bus.mem_WD = wr_dat;
                bus.mem_WE = !bus.abort;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rem_q      <= '0;
            words_q    <= '0;
            buf_q      <= '0;
`ifdef DATA_MEM_DMA_FILL_EN
            fill_q     <= 1'b0;
            fill_val_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.abort && state_q != IDLE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (launch) begin
                        rem_q      <= bus.len;
                        words_q    <= '0;
                        busy_q     <= 1'b1;
`ifdef DATA_MEM_DMA_FILL_EN
                        fill_q     <= bus.fill;
                        fill_val_q <= bus.fill_val;
`endif
                        if (bus.len == '0)
                            state_q <= FIN;
                        else if (fill_start)
                            state_q <= WR;
                        else
                            state_q <= RD;
                    end
                    RD: if (bus.mem_gnt) begin
                        buf_q   <= bus.mem_RD;
                        state_q <= WR;
                    end
                    WR: if (bus.mem_gnt) begin
                        words_q <= words_q + LEN_W'(1);
                        rem_q   <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1))
                            state_q <= FIN;
                        else if (is_fill)
                            state_q <= WR;
                        else
                            state_q <= RD;
                    end
                    FIN: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.words_done = words_q;
endmodule

// File: tb/tb_data_mem_dma.sv
// Randomised and directed bench for data_mem_dma against a word-level copy/fill model.
// Fill-mode cases compile in only with DATA_MEM_DMA_FILL_EN.
module tb_data_mem_dma;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_dma_if bus();
    data_mem_dma dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_a  = '0;
    logic [15:0] pre_d  = '0;

    assign bus.mem_RD = mem[bus.mem_A];
    always @(posedge clk) begin
        if (bus.mem_WE)
            mem[bus.mem_A] <= bus.mem_WD;
        else if (pre_we)
            mem[pre_a] <= pre_d;
    end

    int acc_cnt  = 0;
    bit excl_err = 1'b0;
    bit gnt_err  = 1'b0;
    always @(posedge clk) begin
        if (bus.mem_WE || bus.mem_RE) acc_cnt <= acc_cnt + 1;
        if (bus.mem_WE && bus.mem_RE) excl_err <= 1'b1;
        if ((bus.mem_WE || bus.mem_RE) && !bus.mem_gnt) gnt_err <= 1'b1;
    end

    logic gnt_pat [0:255];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Model: a word needs one granted read then one granted write (fill: one granted write);
    // done follows two cycles after the last required grant.
    task automatic do_xfer(input string tag, input logic [15:0] s, input logic [15:0] d, input int n,
                           input bit fl, input logic [15:0] fv, input int ab, input bit stray,
                           input bit keep_src, output int got_done);
        int need, exp_done, g, words, run_len, acc0, n_pulses;
        logic busy1;
        logic [15:0] a;
        if (!fl && !keep_src)
            for (int i = 0; i < n; i++) poke(s + 16'(i), 16'($urandom));
        for (int i = 0; i <= n; i++) poke(d + 16'(i), 16'($urandom));
        need = fl ? n : 2 * n;
        exp_done = 2;
        g = 0;
        if (n > 0)
            for (int c = 1; c < 256; c++) begin
                if (gnt_pat[c]) g++;
                if (g == need) begin
                    exp_done = c + 2;
                    break;
                end
            end
        words = n;
        if (ab > 0) begin
            g = 0;
            for (int c = 1; c < ab; c++) if (gnt_pat[c]) g++;
            words = fl ? g : g / 2;
            if (words > n) words = n;
        end
        for (int i = 0; i < words; i++) begin
            a = d + 16'(i);
            ref_mem[a] = fl ? fv : ref_mem[s + 16'(i)];
        end
        run_len  = (ab > 0) ? ab + 3 : exp_done + 2;
        acc0     = acc_cnt;
        got_done = -1;
        n_pulses = 0;
        busy1    = 1'b0;
        @(negedge clk);
        bus.src_addr = s;
        bus.dst_addr = d;
        bus.len      = 16'(n);
        bus.start    = 1'b1;
        bus.abort    = 1'b0;
        bus.mem_gnt  = gnt_pat[0];
`ifdef DATA_MEM_DMA_FILL_EN
        bus.fill     = fl;
        bus.fill_val = fv;
`endif
        for (int c = 1; c <= run_len; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) busy1 = bus.busy;
            if (bus.done) begin
                n_pulses++;
                if (got_done < 0) begin
                    got_done = c;
                    chk({tag, "_busy_at_done"}, 32'(bus.busy), 0);
                end
            end
            @(negedge clk);
            bus.start = stray && (c == 3);
            if (stray && c == 3) begin
                bus.src_addr = ~s;
                bus.dst_addr = ~d;
                bus.len      = 16'(n + 5);
            end
            bus.mem_gnt = gnt_pat[c];
            bus.abort   = (c == ab);
        end
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.mem_gnt = 1'b1;
        chk({tag, "_busy_c1"}, 32'(busy1), 1);
        chk({tag, "_done_pulses"}, n_pulses, (ab > 0) ? 0 : 1);
        if (ab == 0) begin
            chk({tag, "_done_cycle"}, got_done, exp_done);
            chk({tag, "_accesses"}, acc_cnt - acc0, need);
        end
        chk({tag, "_busy_end"}, 32'(bus.busy), 0);
        chk({tag, "_words_done"}, 32'(bus.words_done), words);
        for (int i = 0; i <= n; i++) begin
            a = d + 16'(i);
            chk({tag, "_mem"}, 32'(mem[a]), 32'(ref_mem[a]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got, n, ab, need;
        bit fl, stray;
        logic [15:0] s, d;
        bus.start = 1'b0; bus.abort = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
        bus.len = '0; bus.mem_gnt = 1'b1;
`ifdef DATA_MEM_DMA_FILL_EN
        bus.fill = 1'b0; bus.fill_val = '0;
`endif
        for (int c = 0; c < 256; c++) gnt_pat[c] = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_we", 32'(bus.mem_WE), 0);
        chk("rst_re", 32'(bus.mem_RE), 0);
        chk("rst_a", 32'(bus.mem_A), 0);
        chk("rst_wd", 32'(bus.mem_WD), 0);
        chk("rst_words", 32'(bus.words_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        poke(16'h0010, 16'h00A1); poke(16'h0011, 16'h00B2);
        poke(16'h0012, 16'h00C3); poke(16'h0013, 16'h00D4);
        do_xfer("copy4", 16'h0010, 16'h0040, 4, 1'b0, 16'h0, 0, 1'b0, 1'b1, got);
        chk("copy4_done_at_10", got, 10);
        chk("copy4_w0", 32'(mem[16'h0040]), 32'h00A1);
        chk("copy4_w3", 32'(mem[16'h0043]), 32'h00D4);

        do_xfer("len0", 16'h0050, 16'h0060, 0, 1'b0, 16'h0, 0, 1'b0, 1'b0, got);
        chk("len0_done_at_2", got, 2);

        do_xfer("wrap", 16'hFFFF, 16'h0080, 2, 1'b0, 16'h0, 0, 1'b0, 1'b0, got);

        gnt_pat[4] = 1'b0; gnt_pat[5] = 1'b0; gnt_pat[6] = 1'b0;
        do_xfer("stall", 16'h0100, 16'h0140, 4, 1'b0, 16'h0, 0, 1'b0, 1'b0, got);
        chk("stall_done_at_13", got, 13);
        for (int c = 0; c < 256; c++) gnt_pat[c] = 1'b1;

        do_xfer("abort", 16'h0200, 16'h0240, 8, 1'b0, 16'h0, 6, 1'b0, 1'b0, got);
        chk("abort_words_2", 32'(bus.words_done), 2);

`ifdef DATA_MEM_DMA_FILL_EN
        do_xfer("fill", 16'h0000, 16'h0020, 3, 1'b1, 16'hBEEF, 0, 1'b0, 1'b0, got);
        chk("fill_done_at_5", got, 5);
        chk("fill_w2", 32'(mem[16'h0022]), 32'hBEEF);
`endif

        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.len = 16'd3;
        @(posedge clk); #1;
        chk("abort_over_start_busy", 32'(bus.busy), 0);
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;

        for (int i = 0; i < 8; i++) poke(16'h0300 + 16'(i), 16'($urandom));
        for (int i = 0; i < 9; i++) poke(16'h0380 + 16'(i), 16'($urandom));
        @(negedge clk);
        bus.src_addr = 16'h0300; bus.dst_addr = 16'h0380; bus.len = 16'd8; bus.start = 1'b1;
`ifdef DATA_MEM_DMA_FILL_EN
        bus.fill = 1'b0;
`endif
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        chk("mrst_we_before", 32'(bus.mem_WE), 1);
        rst = 1'b0;
        #1;
        chk("mrst_we_async", 32'(bus.mem_WE), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_req", 32'(bus.mem_req), 0);
        chk("mrst_words", 32'(bus.words_done), 0);
        @(negedge clk);
        rst = 1'b1;
        ref_mem[16'h0380] = ref_mem[16'h0300];
        ref_mem[16'h0381] = ref_mem[16'h0301];
        for (int i = 0; i < 3; i++)
            chk("mrst_mem", 32'(mem[16'h0380 + 16'(i)]), 32'(ref_mem[16'h0380 + 16'(i)]));

        for (int it = 0; it < 24; it++) begin
            n = int'($urandom_range(0, 12));
            s = 16'($urandom);
            d = 16'($urandom);
`ifdef DATA_MEM_DMA_FILL_EN
            fl = 1'($urandom);
`else
            fl = 1'b0;
`endif
            for (int c = 0; c < 256; c++)
                gnt_pat[c] = (c >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            need = fl ? n : 2 * n;
            ab = 0;
            if (need > 0 && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, need));
            stray = (ab == 0) && (n >= 2) && 1'($urandom);
            do_xfer("rand", s, d, n, fl, 16'($urandom), ab, stray, 1'b0, got);
        end

        chk("we_re_exclusive", 32'(excl_err), 0);
        chk("access_needs_gnt", 32'(gnt_err), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
